// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// Purpose:
//   Controller/scheduler wrapped around the UART receive FSM datapath.
//   Generates the 16x oversampling strobe and double-flop synchronises the raw
//   RX pin. It sequences the receive FSM through OFF / ARM / RUN, buffers
//   completed bytes in a small FIFO with a valid/ready output, and keeps
//   overrun and frame-error status.
//
// Parameters:
//   DEPTH     FIFO entries (power of 2, >= 2)
//   CNT_W     width of the saturating frame-error counter
//   TO_TICKS  idle strobes before o_timeout (exists only with the macro)
//
// Optional feature:
//   UART_RX_TIMEOUT_EN  when defined, adds an idle-with-data timeout flag.
//                       When undefined, o_timeout is tied low and no idle
//                       counter is built.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_en              receiver enable (level)
//   i_div             clk cycles per sampling strobe (values < 2 act as 2)
//   i_rxd_pin         raw asynchronous RX pin
//   o_rx_rst_n        synchronous reset to the Rx FSM, high only in RUN
//   o_sampling        one-cycle oversampling strobe
//   o_rxd_sync        synchronised RX line
//   i_rx_byte         received byte from the Rx FSM
//   i_rx_complete     frame-good pulse from the Rx FSM
//   i_rx_error        stop-bit-error pulse from the Rx FSM
//   o_data            FIFO head byte
//   o_valid           FIFO non-empty
//   i_ready           consumer pop request (pop = o_valid & i_ready)
//   o_level           FIFO occupancy, 0..DEPTH
//   o_overrun         sticky: a byte was dropped on a full FIFO
//   o_err_cnt         saturating count of frame errors
//   i_clr_status      clears o_overrun, o_err_cnt and o_timeout
//   o_timeout         idle-with-data flag
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
`ifdef UART_RX_TIMEOUT_EN
    , parameter int TO_TICKS = 32
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_en,
    input  logic [15:0]                i_div,
    input  logic                       i_rxd_pin,
    output logic                       o_rx_rst_n,
    output logic                       o_sampling,
    output logic                       o_rxd_sync,
    input  logic [7:0]                 i_rx_byte,
    input  logic                       i_rx_complete,
    input  logic                       i_rx_error,
    output logic [7:0]                 o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overrun,
    output logic [CNT_W-1:0]           o_err_cnt,
    input  logic                       i_clr_status,
    output logic                       o_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ARM,
        ST_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       div_q, div_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [3:0]        arm_cnt_q, arm_cnt_d;
    logic              sampling_q, sampling_d;
    logic              rx_rst_n_q, rx_rst_n_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TO_TICKS + 1);
    logic [TW-1:0]     idle_q, idle_d;
    logic              timeout_q, timeout_d;
`endif

    logic [15:0]       div_eff;
    logic              run;
    logic              valid;
    logic              pop;
    logic              good;
    logic              room;
    logic              push;
    logic              drop;
    logic              err_ev;

    assign div_eff = (i_div < 16'd2) ? 16'd2 : i_div;
    assign run     = (state_q == ST_RUN);
    assign valid   = (level_q != '0);
    assign pop     = valid & i_ready;
    // An error pulse overrides a simultaneous complete pulse.
    assign good    = run & i_rx_complete & ~i_rx_error;
    // A pop in the same cycle frees a slot even when the FIFO is full.
    assign room    = (level_q != LW'(DEPTH)) | pop;
    assign push    = good & room;
    assign drop    = good & ~room;
    assign err_ev  = run & i_rx_error;

    // Next-state logic: sequencer, strobe divider, synchroniser, FIFO, status.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        arm_cnt_d  = arm_cnt_q;
        sync1_d    = i_rxd_pin;
        sync2_d    = sync1_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overrun_d  = overrun_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (i_en) begin
                    state_d   = ST_ARM;
                    div_d     = div_eff;
                    arm_cnt_d = '0;
                end
            end
            ST_ARM: begin
                if (!i_en) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sampling_q ? 16'd0 : cnt_q + 16'd1;
                    // Sixteen consecutive idle-high strobes prove the line is idle.
                    if (sampling_q) begin
                        if (!sync2_q) begin
                            arm_cnt_d = '0;
                        end else if (arm_cnt_q == 4'd15) begin
                            state_d   = ST_RUN;
                            arm_cnt_d = '0;
                        end else begin
                            arm_cnt_d = arm_cnt_q + 4'd1;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (!i_en) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sampling_q ? 16'd0 : cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        // Both outputs are registered decodes of the next state so they line
        // up with state_q and cnt_q in the cycle they describe.
        rx_rst_n_d = (state_d == ST_RUN);
        sampling_d = (state_d != ST_OFF) && (cnt_d == div_d - 16'd1);

        if (push) begin
            mem_d[wr_ptr_q] = i_rx_byte;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A new event in the same cycle as a clear takes precedence.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (i_clr_status) begin
            overrun_d = 1'b0;
        end

        if (err_ev) begin
            if (i_clr_status) begin
                err_cnt_d = CNT_W'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end else if (i_clr_status) begin
            err_cnt_d = '0;
        end

`ifdef UART_RX_TIMEOUT_EN
        idle_d    = idle_q;
        timeout_d = timeout_q;
        if (push || pop || !valid) begin
            idle_d = '0;
        end else if (run && sampling_q && (idle_q != TW'(TO_TICKS))) begin
            idle_d = idle_q + TW'(1);
        end
        if (run && sampling_q && valid && !push && !pop &&
            (idle_q == TW'(TO_TICKS - 1))) begin
            timeout_d = 1'b1;
        end else if (pop || i_clr_status) begin
            timeout_d = 1'b0;
        end
`endif
    end

    // State registers; the synchroniser flops reset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            div_q      <= 16'd2;
            cnt_q      <= '0;
            arm_cnt_q  <= '0;
            sampling_q <= 1'b0;
            rx_rst_n_q <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overrun_q  <= 1'b0;
            err_cnt_q  <= '0;
`ifdef UART_RX_TIMEOUT_EN
            idle_q     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            arm_cnt_q  <= arm_cnt_d;
            sampling_q <= sampling_d;
            rx_rst_n_q <= rx_rst_n_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overrun_q  <= overrun_d;
            err_cnt_q  <= err_cnt_d;
`ifdef UART_RX_TIMEOUT_EN
            idle_q     <= idle_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign o_rx_rst_n = rx_rst_n_q;
    assign o_sampling = sampling_q;
    assign o_rxd_sync = sync2_q;
    assign o_data     = mem_q[rd_ptr_q];
    assign o_valid    = valid;
    assign o_level    = level_q;
    assign o_overrun  = overrun_q;
    assign o_err_cnt  = err_cnt_q;
`ifdef UART_RX_TIMEOUT_EN
    assign o_timeout  = timeout_q;
`else
    assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Purpose:
//   Self-checking bench for uart_rx_ctrl. A behavioural model that uses a
//   queue, an elapsed-cycle count and a mode number tracks the expected
//   outputs, and is compared on every falling edge. Directed sequences add
//   hand-computed expectations for reset, strobe period, arm latency, FIFO
//   ordering, overrun, error counting, abort and (with UART_RX_TIMEOUT_EN)
//   the timeout flag.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DEPTH    = 4;
    localparam int CNT_W    = 8;
    localparam int TO_TICKS = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_en = 1'b0;
    logic [15:0] i_div = 16'd4;
    logic        i_rxd_pin = 1'b1;
    logic        o_rx_rst_n;
    logic        o_sampling;
    logic        o_rxd_sync;
    logic [7:0]  i_rx_byte = 8'h00;
    logic        i_rx_complete = 1'b0;
    logic        i_rx_error = 1'b0;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [2:0]  o_level;
    logic        o_overrun;
    logic [7:0]  o_err_cnt;
    logic        i_clr_status = 1'b0;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_en          (i_en),
        .i_div         (i_div),
        .i_rxd_pin     (i_rxd_pin),
        .o_rx_rst_n    (o_rx_rst_n),
        .o_sampling    (o_sampling),
        .o_rxd_sync    (o_rxd_sync),
        .i_rx_byte     (i_rx_byte),
        .i_rx_complete (i_rx_complete),
        .i_rx_error    (i_rx_error),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_level       (o_level),
        .o_overrun     (o_overrun),
        .o_err_cnt     (o_err_cnt),
        .i_clr_status  (i_clr_status),
        .o_timeout     (o_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model state: mode 0=off, 1=arming, 2=running.
    int          m_mode;
    int          m_div;
    int          m_active;
    int          m_good;
    logic        m_p1;
    logic        m_p2;
    logic [7:0]  m_fifo[$];
    bit          m_ovr;
    int          m_err;
    int          m_idle;
    bit          m_to;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit expStrobe();
        return (m_mode != 0) && ((m_active % m_div) == (m_div - 1));
    endfunction

    function automatic void modelReset();
        m_mode   = 0;
        m_div    = 2;
        m_active = 0;
        m_good   = 0;
        m_p1     = 1'b1;
        m_p2     = 1'b1;
        m_fifo.delete();
        m_ovr    = 1'b0;
        m_err    = 0;
        m_idle   = 0;
        m_to     = 1'b0;
    endfunction

    function automatic void modelStep();
        bit strobe;
        bit line;
        bit valid;
        bit pop;
        bit run;
        bit good;
        bit push;
        bit drop;
        bit hit;
        int e;
        strobe = expStrobe();
        line   = m_p2;
        valid  = (m_fifo.size() > 0);
        pop    = valid && i_ready;
        run    = (m_mode == 2);
        good   = run && i_rx_complete && !i_rx_error;
        push   = 1'b0;
        drop   = 1'b0;
        hit    = 1'b0;
        if (good) begin
            if ((m_fifo.size() - (pop ? 1 : 0)) < DEPTH) push = 1'b1;
            else drop = 1'b1;
        end
        e = i_clr_status ? 0 : m_err;
        if (run && i_rx_error) e = (e + 1 > 255) ? 255 : e + 1;
        m_err = e;
        if (i_clr_status) m_ovr = 1'b0;
        if (drop) m_ovr = 1'b1;
        if (push || pop || !valid) begin
            m_idle = 0;
        end else if (run && strobe && m_idle < TO_TICKS) begin
            m_idle++;
            if (m_idle == TO_TICKS) hit = 1'b1;
        end
`ifdef UART_RX_TIMEOUT_EN
        if (hit) m_to = 1'b1;
        else if (pop || i_clr_status) m_to = 1'b0;
`endif
        if (pop) void'(m_fifo.pop_front());
        if (push) m_fifo.push_back(i_rx_byte);
        case (m_mode)
            0: if (i_en) begin
                m_mode   = 1;
                m_div    = (i_div < 16'd2) ? 2 : int'(i_div);
                m_active = 0;
                m_good   = 0;
            end
            1: if (!i_en) m_mode = 0;
               else begin
                   m_active++;
                   if (strobe) begin
                       if (line) m_good++;
                       else m_good = 0;
                       if (m_good == 16) m_mode = 2;
                   end
               end
            default: if (!i_en) m_mode = 0;
                     else m_active++;
        endcase
        m_p2 = m_p1;
        m_p1 = i_rxd_pin;
    endfunction

    // Model advances on the same edges as the DUT, using the settled inputs.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("rx_rst_n", {31'd0, o_rx_rst_n}, {31'd0, (m_mode == 2)});
        checkOutput("sampling", {31'd0, o_sampling}, {31'd0, expStrobe()});
        checkOutput("rxd_sync", {31'd0, o_rxd_sync}, {31'd0, m_p2});
        checkOutput("valid", {31'd0, o_valid}, {31'd0, (m_fifo.size() > 0)});
        checkOutput("level", {29'd0, o_level}, m_fifo.size());
        if (m_fifo.size() > 0) checkOutput("data", {24'd0, o_data}, {24'd0, m_fifo[0]});
        checkOutput("overrun", {31'd0, o_overrun}, {31'd0, m_ovr});
        checkOutput("err_cnt", {24'd0, o_err_cnt}, m_err);
        checkOutput("timeout", {31'd0, o_timeout}, {31'd0, m_to});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic comp, input logic err,
                                 input logic rdy, input logic clr);
        i_rx_byte     = b;
        i_rx_complete = comp;
        i_rx_error    = err;
        i_ready       = rdy;
        i_clr_status  = clr;
        tick(1);
        i_rx_complete = 1'b0;
        i_rx_error    = 1'b0;
        i_ready       = 1'b0;
        i_clr_status  = 1'b0;
    endtask

    task automatic waitRun(output int n, input int limit);
        n = 0;
        while (!o_rx_rst_n && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    task automatic measurePeriod(input string name, input int expected);
        int first;
        int second;
        first  = -1;
        second = -1;
        for (int n = 0; n < 100 && second < 0; n++) begin
            tick(1);
            if (o_sampling) begin
                if (first < 0) first = n;
                else second = n;
            end
        end
        checkOutput(name, second - first, expected);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rx_rst_n"}, {31'd0, o_rx_rst_n}, 32'd0);
        checkOutput({tag, "_sampling"}, {31'd0, o_sampling}, 32'd0);
        checkOutput({tag, "_rxd_sync"}, {31'd0, o_rxd_sync}, 32'd1);
        checkOutput({tag, "_data"}, {24'd0, o_data}, 32'h00);
        checkOutput({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        checkOutput({tag, "_level"}, {29'd0, o_level}, 32'd0);
        checkOutput({tag, "_overrun"}, {31'd0, o_overrun}, 32'd0);
        checkOutput({tag, "_err_cnt"}, {24'd0, o_err_cnt}, 32'd0);
        checkOutput({tag, "_timeout"}, {31'd0, o_timeout}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] drain_exp [4];
        drain_exp = '{8'h11, 8'h12, 8'h13, 8'h20};

        // Power-on reset values.
        tick(3);
        checkResetValues("por");
        rst_n = 1'b1;
        tick(2);

        // Strobe period with a normal and a clamped divider.
        i_div = 16'd10;
        i_en  = 1'b1;
        measurePeriod("period_div10", 10);
        i_en = 1'b0;
        tick(2);
        checkOutput("sampling_off", {31'd0, o_sampling}, 32'd0);
        i_div = 16'd1;
        i_en  = 1'b1;
        measurePeriod("period_div1", 2);
        i_en = 1'b0;
        tick(2);

        // Arm with a clean idle line: 16 strobes of 4 clocks after entering ARM.
        i_div = 16'd4;
        i_en  = 1'b1;
        waitRun(n, 200);
        checkOutput("arm_latency", n, 65);
        i_en = 1'b0;
        tick(2);
        checkOutput("run_abort_rst", {31'd0, o_rx_rst_n}, 32'd0);

        // Arm again with a low glitch seen at strobe 8: count restarts.
        i_en = 1'b1;
        n = 0;
        while (!o_rx_rst_n && n < 300) begin
            tick(1);
            n++;
            if (n == 30) i_rxd_pin = 1'b0;
            if (n == 31) i_rxd_pin = 1'b1;
        end
        checkOutput("arm_glitch_latency", n, 97);

        // FIFO push/pop ordering.
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("fifo_level2", {29'd0, o_level}, 32'd2);
        checkOutput("fifo_head_a5", {24'd0, o_data}, 32'hA5);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("fifo_head_3c", {24'd0, o_data}, 32'h3C);
        checkOutput("fifo_level1", {29'd0, o_level}, 32'd1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("fifo_empty", {31'd0, o_valid}, 32'd0);

        // Overrun on full FIFO, then complete+pop on full, then clear.
        for (int i = 0; i < 5; i++) applyStimulus(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_level", {29'd0, o_level}, 32'd4);
        checkOutput("ovr_flag", {31'd0, o_overrun}, 32'd1);
        checkOutput("ovr_head", {24'd0, o_data}, 32'h10);
        applyStimulus(8'h20, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("full_pushpop_level", {29'd0, o_level}, 32'd4);
        checkOutput("full_pushpop_head", {24'd0, o_data}, 32'h11);
        checkOutput("full_pushpop_ovr", {31'd0, o_overrun}, 32'd1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovr_cleared", {31'd0, o_overrun}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_order", {24'd0, o_data}, {24'd0, drain_exp[i]});
            applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("drain_level", {29'd0, o_level}, 32'd0);

        // Error counting, error beating complete, clear precedence, saturation.
        for (int i = 0; i < 3; i++) applyStimulus(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("err3", {24'd0, o_err_cnt}, 32'd3);
        applyStimulus(8'h66, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("err4", {24'd0, o_err_cnt}, 32'd4);
        checkOutput("err_no_push", {29'd0, o_level}, 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("err_clr_event", {24'd0, o_err_cnt}, 32'd1);
        i_rx_error = 1'b1;
        tick(260);
        i_rx_error = 1'b0;
        checkOutput("err_saturate", {24'd0, o_err_cnt}, 32'hFF);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("err_cleared", {24'd0, o_err_cnt}, 32'd0);

        // Abort mid-frame keeps FIFO contents; events ignored while off.
        applyStimulus(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        i_en = 1'b0;
        tick(1);
        checkOutput("abort_rst", {31'd0, o_rx_rst_n}, 32'd0);
        checkOutput("abort_level", {29'd0, o_level}, 32'd1);
        checkOutput("abort_data", {24'd0, o_data}, 32'h77);
        applyStimulus(8'h88, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("off_no_push", {29'd0, o_level}, 32'd1);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("off_no_err", {24'd0, o_err_cnt}, 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("off_pop", {29'd0, o_level}, 32'd0);

`ifdef UART_RX_TIMEOUT_EN
        // One byte held unread for TO_TICKS strobes raises the timeout.
        i_div = 16'd2;
        i_en  = 1'b1;
        waitRun(n, 200);
        applyStimulus(8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!o_timeout && n < 200) begin
            tick(1);
            n++;
        end
        checkOutput("timeout_set", {31'd0, o_timeout}, 32'd1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("timeout_pop", {31'd0, o_timeout}, 32'd0);
        i_en = 1'b0;
        tick(1);
`endif

        // Reset asserted mid-run with data and status present.
        i_div = 16'd4;
        i_en  = 1'b1;
        waitRun(n, 200);
        checkOutput("rerun", {31'd0, o_rx_rst_n}, 32'd1);
        for (int i = 0; i < 5; i++) applyStimulus(8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("pre_reset_ovr", {31'd0, o_overrun}, 32'd1);
        @(posedge clk);
        #3;
        i_en  = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetValues("midrun");
        tick(2);
        rst_n = 1'b1;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
